instruction_loader: RTL and testbench

- Write-side companion to instruction_memory. Receives a program as a byte stream and writes it into the instruction memory's write port.
- Stream format: byte stream using a valid/ready handshake, big-endian (high byte first). Two bytes form one 16-bit instruction.
- Writes go to consecutive 10-bit word addresses, starting at a programmable base address.
- Used at boot or from a debug/UART bridge to load programs before the core runs.

---
 rtl/imem_pkg.sv | 49 ++++
 rtl/loader_checksum.sv | 29 ++
 rtl/instruction_loader.sv | 241 ++++++++++++++++++++++++
 tb/tb_instruction_loader.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared instruction-memory package: geometry, loader state encoding and
// instruction field positions reused by the loader and the decoder.
package imem_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int INSTR_W     = 16;
  localparam int BYTE_W      = 8;

  // Loader FSM state encoding (CHK is only reachable in the checksum build)
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    WR   = 3'd3,
    CHK  = 3'd4,
    FIN  = 3'd5
  } load_state_t;

  // Instruction field positions
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 13;
  localparam int RD_MSB   = 12;
  localparam int RD_LSB   = 10;
  localparam int RS_MSB   = 9;
  localparam int RS_LSB   = 7;
  localparam int IMM_MSB  = 6;
  localparam int IMM_LSB  = 0;

  // Opcode field of an instruction word
  function automatic logic [2:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  // Destination register field of an instruction word
  function automatic logic [2:0] get_rd(input logic [INSTR_W-1:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

  // Source register field of an instruction word
  function automatic logic [2:0] get_rs(input logic [INSTR_W-1:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  // Immediate field of an instruction word
  function automatic logic [6:0] get_imm(input logic [INSTR_W-1:0] instr);
    return instr[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/loader_checksum.sv
// XOR accumulator over the program bytes received by the loader.
// Cleared on an accepted start, updated on every accepted program byte.
module loader_checksum
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [BYTE_W-1:0] data,
  output logic [BYTE_W-1:0] sum
);

  logic [BYTE_W-1:0] sum_r;

  // Running XOR; clear has priority over a same-cycle update
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r <= 8'h00;
    end else if (clear) begin
      sum_r <= 8'h00;
    end else if (en) begin
      sum_r <= sum_r ^ data;
    end
  end

  assign sum = sum_r;

endmodule

// File: rtl/instruction_loader.sv
// Instruction loader: assembles a big-endian byte stream into 16-bit words
// and writes them to consecutive instruction-memory addresses.
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN (trailing XOR checksum
// byte, CHK state and csum_err output).
module instruction_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int INSTR_W = imem_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W:0]    word_count,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               busy,
  output logic               done
`ifdef INSTR_LOADER_CHECKSUM_EN
  ,
  output logic               csum_err
`endif
);

  // After the last word (or an empty load) the FSM either checks the
  // trailing checksum byte or finishes directly.
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam load_state_t END_ST = CHK;
`else
  localparam load_state_t END_ST = FIN;
`endif

  load_state_t          state_r;
  load_state_t          state_s;

  logic [ADDR_W-1:0]    addr_r;
  logic [ADDR_W:0]      remain_r;
  logic [7:0]           hi_byte_r;

  logic                 byte_ready_r;
  logic                 mem_we_r;
  logic [ADDR_W-1:0]    mem_addr_r;
  logic [INSTR_W-1:0]   mem_wdata_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 ready_s;
  logic                 we_s;
  logic                 busy_s;
  logic                 done_s;

  logic                 xfer_s;
  logic                 start_acc_s;
  logic                 last_word_s;

  // A byte moves only when the registered ready is high
  assign xfer_s      = byte_valid & byte_ready_r;
  // start is only honoured while idle, which also makes it ignored when busy
  assign start_acc_s = start & (state_r == IDLE);
  assign last_word_s = (remain_r == (ADDR_W+1)'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            state_s = END_ST;
          end else begin
            state_s = HI;
          end
        end else begin
          state_s = IDLE;
        end
      end
      HI: begin
        if (xfer_s) begin
          state_s = LO;
        end else begin
          state_s = HI;
        end
      end
      LO: begin
        if (xfer_s) begin
          state_s = WR;
        end else begin
          state_s = LO;
        end
      end
      WR: begin
        if (last_word_s) begin
          state_s = END_ST;
        end else begin
          state_s = HI;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer_s) begin
          state_s = FIN;
        end else begin
          state_s = CHK;
        end
      end
`endif
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they describe
  always_comb begin
    ready_s = 1'b0;
    we_s    = 1'b0;
    busy_s  = 1'b1;
    done_s  = 1'b0;
    case (state_s)
      IDLE: begin
        busy_s = 1'b0;
      end
      HI, LO, CHK: begin
        ready_s = 1'b1;
      end
      WR: begin
        we_s = 1'b1;
      end
      FIN: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Registered control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_ready_r <= 1'b0;
      mem_we_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      byte_ready_r <= ready_s;
      mem_we_r     <= we_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  // Write pointer and remaining-word count; address wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r   <= '0;
      remain_r <= '0;
    end else if (start_acc_s) begin
      addr_r   <= base_addr;
      remain_r <= word_count;
    end else if (state_r == WR) begin
      addr_r   <= addr_r + ADDR_W'(1);
      remain_r <= remain_r - (ADDR_W+1)'(1);
    end
  end

  // Word assembly: high byte is held until the low byte arrives, then the
  // whole word and its address are presented for the WR cycle and held
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_byte_r   <= 8'h00;
      mem_wdata_r <= '0;
      mem_addr_r  <= '0;
    end else begin
      if ((state_r == HI) && xfer_s) begin
        hi_byte_r <= byte_in;
      end
      if ((state_r == LO) && xfer_s) begin
        mem_wdata_r <= {hi_byte_r, byte_in};
        mem_addr_r  <= addr_r;
      end
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] csum_s;
  logic       csum_err_r;
  logic       csum_en_s;

  assign csum_en_s = xfer_s & ((state_r == HI) | (state_r == LO));

  loader_checksum u_checksum (
    .clk   (clk),
    .reset (reset),
    .clear (start_acc_s),
    .en    (csum_en_s),
    .data  (byte_in),
    .sum   (csum_s)
  );

  // Checksum verdict becomes visible together with done and is held
  // until the next accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_err_r <= 1'b0;
    end else if (start_acc_s) begin
      csum_err_r <= 1'b0;
    end else if ((state_r == CHK) && xfer_s) begin
      csum_err_r <= (byte_in != csum_s);
    end
  end

  assign csum_err = csum_err_r;
`endif

  assign byte_ready = byte_ready_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader.
// Honours INSTR_LOADER_CHECKSUM_EN the same way as the design.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic        csum_err;
`endif

  int checks = 0;
  int errors = 0;

  int we_total   = 0;
  int done_total = 0;
  int rdy_viol   = 0;
  logic [9:0]  log_addr [$];
  logic [15:0] log_data [$];
  logic [15:0] mem_model [0:1023];
  logic [7:0]  csum_unused;

  instruction_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done)
`ifdef INSTR_LOADER_CHECKSUM_EN
    ,
    .csum_err   (csum_err)
`endif
  );

  always #5 clk = ~clk;

  // Memory-side observer: records every write and every done pulse
  always @(negedge clk) begin
    if (mem_we) begin
      we_total++;
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      mem_model[mem_addr] = mem_wdata;
      if (byte_ready) rdy_viol++;
    end
    if (done) done_total++;
  end

  task automatic pulse_start(input logic [9:0] b, input logic [10:0] c);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Present one byte after 'gap' idle cycles and hold it until accepted
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL byte_accept: byte %h not accepted, waited %0d want <100", b, n);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_csum(input logic [7:0] b);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(b, 0);
`else
    csum_unused = b;
`endif
  endtask

  task automatic wait_done(input int budget, output bit seen, output int cycles);
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  // Compare the write log against expected address/data lists
  task automatic check_log(input string name, input logic [9:0] ea [], input logic [15:0] ed []);
    checks++;
    if (log_addr.size() !== ea.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d writes want %0d", name, log_addr.size(), ea.size());
    end else begin
      for (int i = 0; i < ea.size(); i++) begin
        checks++;
        if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) begin
          errors++;
          $display("FAIL %s_w%0d: got %h@%0d want %h@%0d", name, i, log_data[i], log_addr[i], ed[i], ea[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    base_addr = 10'd0; word_count = 11'd0;
    repeat (3) @(negedge clk);
    start = 1'b1; word_count = 11'd3;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({byte_ready, mem_we, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got ready/we/busy/done=%b want 0000", {byte_ready, mem_we, busy, done});
    end
    checks++;
    if (mem_addr !== 10'd0 || mem_wdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h@%0d want 0000@0", mem_wdata, mem_addr);
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    checks++;
    if (csum_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_csum: got %b want 0", csum_err);
    end
`endif
  endtask

  task automatic test_nominal();
    bit seen; int cyc; int d0;
    logic [7:0] bytes [8] = '{8'h2C, 8'h03, 8'h81, 8'h80, 8'h24, 8'h04, 8'h00, 8'h83};
    clear_log();
    d0 = done_total;
    pulse_start(10'd0, 11'd4);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL nominal_busy: got %b want 1", busy);
    end
    for (int i = 0; i < 8; i++) send_byte(bytes[i], 0);
    send_csum(8'h8D);
    wait_done(20, seen, cyc);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL nominal_done: got no done want pulse");
    end
    repeat (2) @(negedge clk);
    check_log("nominal", '{10'd0, 10'd1, 10'd2, 10'd3}, '{16'h2C03, 16'h8180, 16'h2404, 16'h0083});
    checks++;
    if (mem_model[0] !== 16'h2C03 || mem_model[1] !== 16'h8180 ||
        mem_model[2] !== 16'h2404 || mem_model[3] !== 16'h0083) begin
      errors++;
      $display("FAIL nominal_readback: got %h %h %h %h want 2c03 8180 2404 0083",
               mem_model[0], mem_model[1], mem_model[2], mem_model[3]);
    end
    checks++;
    if (done_total - d0 !== 1) begin
      errors++;
      $display("FAIL nominal_done_count: got %0d want 1", done_total - d0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL nominal_idle_busy: got %b want 0", busy);
    end
    checks++;
    if (mem_addr !== 10'd3 || mem_wdata !== 16'h0083) begin
      errors++;
      $display("FAIL nominal_hold: got %h@%0d want 0083@3", mem_wdata, mem_addr);
    end
  endtask

  task automatic test_stall();
    bit seen; int cyc; int w0; int r0;
    logic [7:0] bytes [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    clear_log();
    w0 = we_total; r0 = rdy_viol;
    pulse_start(10'd100, 11'd2);
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 5);
    send_csum(8'h08);
    wait_done(20, seen, cyc);
    repeat (2) @(negedge clk);
    checks++;
    if (we_total - w0 !== 2) begin
      errors++;
      $display("FAIL stall_we_pulses: got %0d want 2", we_total - w0);
    end
    checks++;
    if (rdy_viol - r0 !== 0) begin
      errors++;
      $display("FAIL stall_ready_in_wr: got %0d want 0", rdy_viol - r0);
    end
    check_log("stall", '{10'd100, 10'd101}, '{16'h1234, 16'h5678});
  endtask

  task automatic test_wrap();
    bit seen; int cyc;
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_log();
    pulse_start(10'd1023, 11'd2);
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 0);
    send_csum(8'h44);
    wait_done(20, seen, cyc);
    repeat (2) @(negedge clk);
    check_log("wrap", '{10'd1023, 10'd0}, '{16'h1122, 16'h3344});
  endtask

  task automatic test_zero_count();
    bit seen; int cyc; int w0; int d0;
    w0 = we_total; d0 = done_total;
    pulse_start(10'd50, 11'd0);
    send_csum(8'h00);
    wait_done(3, seen, cyc);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL zero_done: got no done within %0d cycles want pulse", cyc);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (we_total - w0 !== 0) begin
      errors++;
      $display("FAIL zero_no_write: got %0d writes want 0", we_total - w0);
    end
    checks++;
    if (done_total - d0 !== 1) begin
      errors++;
      $display("FAIL zero_done_count: got %0d want 1", done_total - d0);
    end
  endtask

  task automatic test_ignored_start();
    bit seen; int cyc;
    clear_log();
    pulse_start(10'd10, 11'd2);
    send_byte(8'hA1, 0);
    pulse_start(10'd200, 11'd5);
    send_byte(8'hB2, 0);
    send_byte(8'hC3, 0);
    send_byte(8'hD4, 0);
    send_csum(8'h04);
    wait_done(20, seen, cyc);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ignored_done: got no done want pulse");
    end
    repeat (2) @(negedge clk);
    check_log("ignored_start", '{10'd10, 10'd11}, '{16'hA1B2, 16'hC3D4});
  endtask

  task automatic test_reset_mid();
    bit seen; int cyc;
    clear_log();
    pulse_start(10'd20, 11'd1);
    send_byte(8'hAB, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({byte_ready, mem_we, busy, done} !== 4'b0000 || mem_addr !== 10'd0 || mem_wdata !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_outputs: got ready/we/busy/done=%b %h@%0d want 0000 0000@0",
               {byte_ready, mem_we, busy, done}, mem_wdata, mem_addr);
    end
    @(negedge clk);
    pulse_start(10'd5, 11'd1);
    send_byte(8'hCD, 0);
    send_byte(8'hEF, 0);
    send_csum(8'h22);
    wait_done(20, seen, cyc);
    repeat (2) @(negedge clk);
    check_log("midreset", '{10'd5}, '{16'hCDEF});
  endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit seen; int cyc;
    pulse_start(10'd40, 11'd1);
    send_byte(8'h2C, 0);
    send_byte(8'h03, 0);
    send_byte(8'h2F, 0);
    wait_done(20, seen, cyc);
    checks++;
    if (!seen || csum_err !== 1'b0) begin
      errors++;
      $display("FAIL csum_good: got done=%b csum_err=%b want 1 0", seen, csum_err);
    end
    repeat (2) @(negedge clk);
    pulse_start(10'd41, 11'd1);
    send_byte(8'h2C, 0);
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    wait_done(20, seen, cyc);
    checks++;
    if (!seen || csum_err !== 1'b1) begin
      errors++;
      $display("FAIL csum_bad: got done=%b csum_err=%b want 1 1", seen, csum_err);
    end
    repeat (2) @(negedge clk);
    pulse_start(10'd42, 11'd0);
    checks++;
    if (csum_err !== 1'b0) begin
      errors++;
      $display("FAIL csum_clear_on_start: got %b want 0", csum_err);
    end
    send_byte(8'h00, 0);
    wait_done(20, seen, cyc);
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_wrap();
    test_zero_count();
    test_ignored_start();
    test_reset_mid();
`ifdef INSTR_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
